div_seq: RTL

- Multi-cycle 32-bit integer divider sequencer for the EX stage; serves DIV/DIVU.
- Runs a radix-2 restoring division, one quotient bit per cycle.
- Raises a stall request to the pipeline controller while busy.
- Returns {remainder, quotient} for EX to forward, with its HI/LO write enable, into the EX/MEM register (HI = remainder, LO = quotient).

---
 rtl/div_seq_pkg.sv | 15 +
 rtl/div_seq_if.sv | 17 +
 rtl/div_seq.sv | 106 ++++++++++
 3 files changed

// File: rtl/div_seq_pkg.sv
// div_seq_pkg: state encodings and shared constants for the sequential divider
package div_seq_pkg;
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;
  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;
  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic [31:0] ZeroWord          = 32'h0;
  localparam logic        RstEnable         = 1'b0;
endpackage

// File: rtl/div_seq_if.sv
// div_seq_if: EX-stage <-> divider handshake bundle
// master (EX): drives start_i, signed_i, opdata1_i, opdata2_i, annul_i
// slave (divider): drives result_o {rem, quo}, ready_o, stallreq_o
interface div_seq_if #(parameter int WIDTH = 32);
  logic               start_i;
  logic               signed_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               stallreq_o;
  modport master (output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
                  input  result_o, ready_o, stallreq_o);
  modport slave  (input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
                  output result_o, ready_o, stallreq_o);
endinterface

// File: rtl/div_seq.sv
// div_seq: radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle
// clk, rst_n (sync, active-low); bus: div_seq_if.slave
// result_o = {remainder, quotient}, ready_o while in END, stallreq_o while EX waits
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic      clk,
  input logic      rst_n,
  div_seq_if.slave bus
);
  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH:0]   work_q, work_d, work_nx;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               neg1_q, neg1_d, neg2_q, neg2_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;
  logic               neg1, neg2;
  logic [WIDTH-1:0]   op1_abs, op2_abs, quo, rem;
  logic [WIDTH:0]     trial;
  // sign flags already masked by signed_i, so DIVU never negates anything
  assign neg1    = bus.signed_i & bus.opdata1_i[WIDTH-1];
  assign neg2    = bus.signed_i & bus.opdata2_i[WIDTH-1];
  assign op1_abs = neg1 ? -bus.opdata1_i : bus.opdata1_i;
  assign op2_abs = neg2 ? -bus.opdata2_i : bus.opdata2_i;
  assign trial   = {1'b0, work_q[2*WIDTH-1:WIDTH]} - {1'b0, dvs_q};
  assign work_nx = trial[WIDTH] ? {work_q[2*WIDTH-1:0], 1'b0}
                                : {trial[WIDTH-1:0], work_q[WIDTH-1:0], 1'b1};
  // after the final shift the remainder sits one bit above the upper half
  assign quo     = (neg1_q ^ neg2_q) ? -work_nx[WIDTH-1:0] : work_nx[WIDTH-1:0];
  assign rem     = neg1_q ? -work_nx[2*WIDTH:WIDTH+1] : work_nx[2*WIDTH:WIDTH+1];
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    dvs_d    = dvs_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    result_d = result_q;
    ready_d  = ready_q;
    if (state_q != DivFree && bus.annul_i) begin
      state_d  = DivFree;
      cnt_d    = '0;
      result_d = '0;
      ready_d  = DivResultNotReady;
    end else begin
      case (state_q)
        DivFree: if (bus.start_i == DivStart && !bus.annul_i) begin
          state_d = (bus.opdata2_i == ZeroWord) ? DivByZero : DivOn;
          cnt_d   = '0;
          work_d  = {{WIDTH{1'b0}}, op1_abs, 1'b0};
          dvs_d   = op2_abs;
          neg1_d  = neg1;
          neg2_d  = neg2;
        end
        DivByZero: begin
          state_d  = DivEnd;
          result_d = '0;
          ready_d  = DivResultReady;
        end
        DivOn: begin
          cnt_d  = cnt_q + 1'b1;
          work_d = work_nx;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = DivEnd;
            result_d = {rem, quo};
            ready_d  = DivResultReady;
          end
        end
        DivEnd: if (bus.start_i == DivStop) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end
        default: state_d = DivFree;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n == RstEnable) begin
      state_q  <= DivFree;
      cnt_q    <= '0;
      work_q   <= '0;
      dvs_q    <= '0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= DivResultNotReady;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      dvs_q    <= dvs_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end
  assign bus.result_o   = result_q;
  assign bus.ready_o    = ready_q;
  assign bus.stallreq_o = bus.start_i & ~bus.annul_i & ~ready_q;
endmodule
